// File: rtl/add_accumulator.sv
// Burst accumulator: sums operand beats until in_last, then holds sum/carry/count for a handshake.
// Define ACC_SATURATE_EN to clamp the accumulator at all ones instead of wrapping.
module add_accumulator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WIDTH:0]     add_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic [CNT_W-1:0]   count_inc_s;

    assign add_s       = {1'b0, acc_q} + {1'b0, in_data};
    assign count_inc_s = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);

`ifdef ACC_SATURATE_EN
    assign acc_next_s  = add_s[WIDTH] ? {WIDTH{1'b1}} : add_s[WIDTH-1:0];
`else
    assign acc_next_s  = add_s[WIDTH-1:0];
`endif

    // count is only zero straight out of reset; it doubles as the "not yet ready" marker in IDLE
    assign in_ready  = ((state_q == IDLE) && (count_q != CNT_ZERO)) || (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_count = count_q;

    // Next-state and datapath update for the three-state burst FSM
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (count_q == CNT_ZERO) begin
                    count_d = CNT_ONE;
                end else if (in_valid) begin
                    acc_d   = in_data;
                    carry_d = 1'b0;
                    count_d = CNT_ONE;
                    state_d = in_last ? HOLD : ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d   = acc_next_s;
                    carry_d = carry_q | add_s[WIDTH];
                    count_d = count_inc_s;
                    state_d = in_last ? HOLD : ACC;
                end else begin
                    state_d = ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            count_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_add_accumulator.sv
// Randomized and directed bench for add_accumulator with a burst-level reference model.
module tb_add_accumulator;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: running integer total and beat count of the current burst
    logic m_warm;
    logic m_pend;
    int   m_tot;
    int   m_cnt;

    add_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_sum(input int tot);
`ifdef ACC_SATURATE_EN
        return (tot >= 16) ? 15 : tot;
`else
        return tot % 16;
`endif
    endfunction

    // Reference model: acceptance and handshake decided from the burst rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_warm <= 1'b0;
            m_pend <= 1'b0;
            m_tot  <= 0;
            m_cnt  <= 0;
        end else begin
            m_warm <= 1'b1;
            if (m_pend) begin
                if (out_ready) begin
                    m_pend <= 1'b0;
                    m_tot  <= 0;
                    m_cnt  <= 0;
                end
            end else if (m_warm && in_valid) begin
                m_tot <= m_tot + int'(in_data);
                m_cnt <= m_cnt + 1;
                if (in_last) m_pend <= 1'b1;
            end
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", out_sum, 0);
            chk("rst_carry", out_carry, 0);
            chk("rst_count", out_count, 0);
        end else begin
            chk("in_ready", in_ready, (m_warm && !m_pend) ? 1 : 0);
            chk("out_valid", out_valid, m_pend ? 1 : 0);
            if (m_pend) begin
                chk("sum", out_sum, exp_sum(m_tot));
                chk("carry", out_carry, (m_tot >= 16) ? 1 : 0);
                chk("count", out_count, (m_cnt > 255) ? 255 : m_cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string nm, input int s, input int c, input int n);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_sum"}, out_sum, s);
        chk({nm, "_carry"}, out_carry, c);
        chk({nm, "_count"}, out_count, n);
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        repeat (3) step();
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", in_ready, 0);
        step();
        chk("ready_after_edge", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("async_rst_ready", in_ready, 0);
        reset_seq();

        send(4'd4, 1'b0); send(4'd2, 1'b0); send(4'd7, 1'b1);
        chk_result("wrap_basic", 13, 0, 3);
        step();
        chk("one_cycle_valid", out_valid, 0);
        chk("idle_ready", in_ready, 1);

        send(4'd7, 1'b0); send(4'd5, 1'b0); send(4'd9, 1'b1);
`ifdef ACC_SATURATE_EN
        chk_result("carry_burst", 15, 1, 3);
`else
        chk_result("carry_burst", 5, 1, 3);
`endif
        step();

        send(4'd9, 1'b1);
        chk_result("single", 9, 0, 1);
        step();

        out_ready = 1'b0;
        send(4'd3, 1'b0); send(4'd3, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'd15;
        for (int i = 0; i < 5; i++) begin
            chk_result("hold", 6, 0, 2);
            chk("hold_ready", in_ready, 0);
            if (i < 4) step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold_release_valid", out_valid, 0);
        chk("hold_release_ready", in_ready, 1);

        send(4'd1, 1'b0);
        in_data = 4'd15;
        step(); step();
        send(4'd2, 1'b1);
        chk_result("gaps", 3, 0, 2);
        step();

        send(4'd5, 1'b0); send(4'd6, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", out_sum, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        step();
        reset_seq();
        send(4'd1, 1'b0); send(4'd1, 1'b1);
        chk_result("after_rst", 2, 0, 2);
        step();

        for (int i = 0; i < 299; i++) send(4'd1, 1'b0);
        send(4'd1, 1'b1);
`ifdef ACC_SATURATE_EN
        chk_result("count_sat", 15, 1, 255);
`else
        chk_result("count_sat", 12, 1, 255);
`endif
        step();

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = WIDTH'($urandom_range(0, 15));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if (i == 300) rst_n = 1'b0;
            if (i == 302) rst_n = 1'b1;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
